// File: rtl/dfir_coef_loader_if.sv
// dfir_coef_loader_if
//   Bundle of the configuration-burst handshake and the coefficient read port
//   between the DFIR configuration controller / FIR MAC pipeline (master) and
//   the coefficient loader (slave).
//
//   isConfig        master -> slave  one-cycle burst start strobe
//   Data_Config_In  master -> slave  config word stream (CONFIG_WIDTH)
//   isConfigACK     slave -> master  load in progress
//   isConfigDone    slave -> master  one-cycle completion pulse
//   Coef_Rd_Addr    master -> slave  coefficient index (ADDR_WIDTH)
//   Coef_Rd_Data    slave -> master  coefficient, one-cycle latency
//   isCoefSym       slave -> master  active symmetry flag
//   ScalVal         slave -> master  active output scale value
//   Coef_Valid      slave -> master  active bank holds a complete set
interface dfir_coef_loader_if #(
  parameter int CONFIG_WIDTH    = 32,
  parameter int FIR_COEFF_WIDTH = 24,
  parameter int SCAL_WIDTH      = 6,
  parameter int ADDR_WIDTH      = 9
);
  logic                       isConfig;
  logic [CONFIG_WIDTH-1:0]    Data_Config_In;
  logic                       isConfigACK;
  logic                       isConfigDone;
  logic [ADDR_WIDTH-1:0]      Coef_Rd_Addr;
  logic [FIR_COEFF_WIDTH-1:0] Coef_Rd_Data;
  logic                       isCoefSym;
  logic [SCAL_WIDTH-1:0]      ScalVal;
  logic                       Coef_Valid;

  modport master (
    output isConfig, Data_Config_In, Coef_Rd_Addr,
    input  isConfigACK, isConfigDone, Coef_Rd_Data, isCoefSym, ScalVal, Coef_Valid
  );

  modport slave (
    input  isConfig, Data_Config_In, Coef_Rd_Addr,
    output isConfigACK, isConfigDone, Coef_Rd_Data, isCoefSym, ScalVal, Coef_Valid
  );
endinterface

// File: rtl/dfir_coef_loader.sv
// dfir_coef_loader
//   FIR-side configuration responder. Captures a burst of FIR_MAX_ORDER+1
//   coefficients, a symmetry flag and a scale value following an isConfig
//   strobe, commits them as the active set, and serves coefficients to the
//   FIR MAC pipeline through a registered read port.
//
//   Ports:
//     CLK   clock
//     nRST  synchronous active-low reset
//     bus   dfir_coef_loader_if.slave (burst handshake + read port)
//
//   Build option:
//     DFIR_COEF_DBUF_EN  defined   -> two banks; loads fill the inactive bank
//                                     while the FIR keeps reading the old set.
//                        undefined -> single bank written in place; reads
//                                     return 0 while a load is in progress.
//
//   state | meaning
//   IDLE  | waiting for isConfig
//   LOAD  | consuming one config word per cycle
//   DONE  | one-cycle completion, new set already active
module dfir_coef_loader #(
  parameter int FIR_MAX_ORDER   = 256,
  parameter int CONFIG_WIDTH    = 32,
  parameter int FIR_COEFF_WIDTH = 24,
  parameter int SCAL_WIDTH      = 6,
  parameter int ADDR_WIDTH      = 9
) (
  input logic              CLK,
  input logic              nRST,
  dfir_coef_loader_if.slave bus
);

  localparam int NCOEF = FIR_MAX_ORDER + 1;
  // One extra bit so the counter can index past the coefficients to the
  // sym and scal slots.
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0]      LAST_COEF_IDX = CNT_W'(FIR_MAX_ORDER);
  localparam logic [CNT_W-1:0]      SYM_IDX       = CNT_W'(FIR_MAX_ORDER + 1);
  localparam logic [CNT_W-1:0]      SCAL_IDX      = CNT_W'(FIR_MAX_ORDER + 2);
  localparam logic [ADDR_WIDTH-1:0] MAX_RD_ADDR   = ADDR_WIDTH'(FIR_MAX_ORDER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ack_q, ack_d;
  logic                       done_q, done_d;
  logic                       sym_sh_q, sym_sh_d;
  logic                       sym_q, sym_d;
  logic [SCAL_WIDTH-1:0]      scal_q, scal_d;
  logic                       valid_q, valid_d;
  logic [FIR_COEFF_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                       coef_we;
  logic [ADDR_WIDTH-1:0]      wr_idx;
  logic [FIR_COEFF_WIDTH-1:0] wr_word;
  logic                       rd_in_range;
  logic [ADDR_WIDTH-1:0]      rd_idx;
  logic [FIR_COEFF_WIDTH-1:0] rd_word;

  // Config bits above the used widths are intentionally dropped.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^bus.Data_Config_In;

  assign coef_we     = (state_q == ST_LOAD) && (cnt_q <= LAST_COEF_IDX);
  assign wr_idx      = cnt_q[ADDR_WIDTH-1:0];
  assign wr_word     = bus.Data_Config_In[FIR_COEFF_WIDTH-1:0];
  assign rd_in_range = (bus.Coef_Rd_Addr <= MAX_RD_ADDR);
  // Keep the array index in range even when the request is not.
  assign rd_idx      = rd_in_range ? bus.Coef_Rd_Addr : '0;

`ifdef DFIR_COEF_DBUF_EN
  logic                       bank_sel_q, bank_sel_d;
  logic [FIR_COEFF_WIDTH-1:0] bank0_mem [NCOEF];
  logic [FIR_COEFF_WIDTH-1:0] bank1_mem [NCOEF];

  // Storage is deliberately not reset; Coef_Valid gates every read.
  always_ff @(posedge CLK) begin
    if (coef_we) begin
      if (bank_sel_q) bank0_mem[wr_idx] <= wr_word;
      else            bank1_mem[wr_idx] <= wr_word;
    end
  end

  assign rd_word = bank_sel_q ? bank1_mem[rd_idx] : bank0_mem[rd_idx];
`else
  logic [FIR_COEFF_WIDTH-1:0] coef_mem [NCOEF];

  always_ff @(posedge CLK) begin
    if (coef_we) coef_mem[wr_idx] <= wr_word;
  end

  assign rd_word = coef_mem[rd_idx];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    sym_sh_d = sym_sh_q;
    sym_d    = sym_q;
    scal_d   = scal_q;
    valid_d  = valid_q;
`ifdef DFIR_COEF_DBUF_EN
    bank_sel_d = bank_sel_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.isConfig) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          ack_d   = 1'b1;
`ifndef DFIR_COEF_DBUF_EN
          // The single bank is about to be overwritten in place.
          valid_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (cnt_q != SCAL_IDX) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SYM_IDX) sym_sh_d = bus.Data_Config_In[0];
        if (cnt_q == SCAL_IDX) begin
          // Commit: the new set becomes active on the same edge as DONE.
          state_d = ST_DONE;
          done_d  = 1'b1;
          sym_d   = sym_sh_q;
          scal_d  = bus.Data_Config_In[SCAL_WIDTH-1:0];
          valid_d = 1'b1;
`ifdef DFIR_COEF_DBUF_EN
          bank_sel_d = ~bank_sel_q;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase

    rd_data_d = (valid_q && rd_in_range) ? rd_word : '0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      sym_sh_q  <= 1'b0;
      sym_q     <= 1'b0;
      scal_q    <= '0;
      valid_q   <= 1'b0;
      rd_data_q <= '0;
`ifdef DFIR_COEF_DBUF_EN
      bank_sel_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      sym_sh_q  <= sym_sh_d;
      sym_q     <= sym_d;
      scal_q    <= scal_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
`ifdef DFIR_COEF_DBUF_EN
      bank_sel_q <= bank_sel_d;
`endif
    end
  end

  assign bus.isConfigACK  = ack_q;
  assign bus.isConfigDone = done_q;
  assign bus.Coef_Rd_Data = rd_data_q;
  assign bus.isCoefSym    = sym_q;
  assign bus.ScalVal      = scal_q;
  assign bus.Coef_Valid   = valid_q;

endmodule

// File: tb/tb_dfir_coef_loader.sv
module tb_dfir_coef_loader;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int W  = 24;
  localparam int SW = 6;
  localparam int AW = 3;
`ifdef DFIR_COEF_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  dfir_coef_loader_if #(.CONFIG_WIDTH(CW), .FIR_COEFF_WIDTH(W),
                        .SCAL_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

  dfir_coef_loader #(.FIR_MAX_ORDER(N), .CONFIG_WIDTH(CW), .FIR_COEFF_WIDTH(W),
                     .SCAL_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // Reference model of the architecturally visible active set.
  logic [W-1:0]  m_coef [N+1];
  logic          m_valid;
  logic          m_sym;
  logic [SW-1:0] m_scal;
  logic [W-1:0]  pending;      // expected Coef_Rd_Data in the next cycle
  logic [CW-1:0] burst_w [N+3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_read(input int a);
    bus.Coef_Rd_Addr = AW'(a);
    if (m_valid && a <= N) pending = m_coef[a];
    else pending = '0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N+3; k++) burst_w[k] = $urandom;
  endtask

  // Drives one burst (isConfig in cycle c=0) and checks every output each
  // cycle against the model. Cycle c is T+c.
  task automatic do_burst(input int rp_a, input int rp_b, input int fixed_addr,
                          input int abort_at, input int last_c);
    logic [W-1:0]  nc [N+1];
    logic          ns;
    logic [SW-1:0] nsc;
    logic          e_ack, e_done, e_valid, e_sym;
    logic [SW-1:0] e_scal;
    int            a;
    for (int k = 0; k <= N; k++) nc[k] = burst_w[k][W-1:0];
    ns  = burst_w[N+1][0];
    nsc = burst_w[N+2][SW-1:0];
    for (int c = 0; c <= last_c; c++) begin
      e_ack  = (c >= 1) && (c <= N+4);
      e_done = (c == N+4);
      if (c == 0)        e_valid = m_valid;
      else if (c >= N+4) e_valid = 1'b1;
      else               e_valid = DBUF ? m_valid : 1'b0;
      e_sym  = (c >= N+4) ? ns  : m_sym;
      e_scal = (c >= N+4) ? nsc : m_scal;

      n_cmp++;
      if (bus.isConfigACK !== e_ack) begin
        n_bad++; $display("FAIL ack c=%0d got %b want %b", c, bus.isConfigACK, e_ack);
      end
      n_cmp++;
      if (bus.isConfigDone !== e_done) begin
        n_bad++; $display("FAIL done c=%0d got %b want %b", c, bus.isConfigDone, e_done);
      end
      n_cmp++;
      if (bus.Coef_Valid !== e_valid) begin
        n_bad++; $display("FAIL valid c=%0d got %b want %b", c, bus.Coef_Valid, e_valid);
      end
      n_cmp++;
      if (bus.isCoefSym !== e_sym) begin
        n_bad++; $display("FAIL sym c=%0d got %b want %b", c, bus.isCoefSym, e_sym);
      end
      n_cmp++;
      if (bus.ScalVal !== e_scal) begin
        n_bad++; $display("FAIL scal c=%0d got %0d want %0d", c, bus.ScalVal, e_scal);
      end
      n_cmp++;
      if (bus.Coef_Rd_Data !== pending) begin
        n_bad++; $display("FAIL rd_burst c=%0d got %h want %h", c, bus.Coef_Rd_Data, pending);
      end

      if (c == abort_at) begin
        nRST = 1'b0;
        bus.isConfig = 1'b0;
        tick();
        nRST = 1'b1;
        n_cmp++;
        if ({bus.isConfigACK, bus.isConfigDone, bus.isCoefSym, bus.Coef_Valid} !== 4'b0000 ||
            bus.ScalVal !== '0 || bus.Coef_Rd_Data !== '0) begin
          n_bad++;
          $display("FAIL abort_reset got ack=%b done=%b sym=%b valid=%b scal=%0d rd=%h want all 0",
                   bus.isConfigACK, bus.isConfigDone, bus.isCoefSym, bus.Coef_Valid,
                   bus.ScalVal, bus.Coef_Rd_Data);
        end
        m_valid = 1'b0; m_sym = 1'b0; m_scal = '0; pending = '0;
        return;
      end

      a = (fixed_addr >= 0) ? fixed_addr : int'($urandom_range(0, 7));
      bus.isConfig       = (c == 0) || (c == rp_a) || (c == rp_b);
      bus.Data_Config_In = (c >= 1 && c <= N+3) ? burst_w[c-1] : CW'($urandom);
      bus.Coef_Rd_Addr   = AW'(a);
      if (e_valid && a <= N) pending = (c >= N+4) ? nc[a] : m_coef[a];
      else pending = '0;
      tick();
    end
    bus.isConfig = 1'b0;
    for (int k = 0; k <= N; k++) m_coef[k] = nc[k];
    m_valid = 1'b1; m_sym = ns; m_scal = nsc;
  endtask

  task automatic do_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      n_cmp++;
      if (bus.isConfigACK !== 1'b0 || bus.isConfigDone !== 1'b0 ||
          bus.Coef_Valid !== m_valid || bus.isCoefSym !== m_sym || bus.ScalVal !== m_scal) begin
        n_bad++;
        $display("FAIL idle_status got ack=%b done=%b valid=%b sym=%b scal=%0d want 0 0 %b %b %0d",
                 bus.isConfigACK, bus.isConfigDone, bus.Coef_Valid, bus.isCoefSym, bus.ScalVal,
                 m_valid, m_sym, m_scal);
      end
      n_cmp++;
      if (bus.Coef_Rd_Data !== pending) begin
        n_bad++; $display("FAIL idle_rd got %h want %h", bus.Coef_Rd_Data, pending);
      end
      bus.isConfig = 1'b0;
      bus.Data_Config_In = $urandom;
      issue_read(int'($urandom_range(0, 7)));
      tick();
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.isConfig = 1'b0;
    bus.Data_Config_In = '0;
    bus.Coef_Rd_Addr = '0;
    repeat (3) tick();
    n_cmp++;
    if ({bus.isConfigACK, bus.isConfigDone, bus.isCoefSym, bus.Coef_Valid} !== 4'b0000 ||
        bus.ScalVal !== '0 || bus.Coef_Rd_Data !== '0) begin
      n_bad++;
      $display("FAIL reset got ack=%b done=%b sym=%b valid=%b scal=%0d rd=%h want all 0",
               bus.isConfigACK, bus.isConfigDone, bus.isCoefSym, bus.Coef_Valid,
               bus.ScalVal, bus.Coef_Rd_Data);
    end
    nRST = 1'b1;
    m_valid = 1'b0; m_sym = 1'b0; m_scal = '0; pending = '0;
    for (int k = 0; k <= N; k++) m_coef[k] = '0;
    do_idle(3);
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_rd [8];
    exp_rd = '{24'h11, 24'h22, 24'h33, 24'h44, 24'h55, 24'h0, 24'h0, 24'h0};
    burst_w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h1, 32'h0A};
    do_burst(-1, -1, -1, -1, N+6);
    n_cmp++;
    if (bus.isCoefSym !== 1'b1 || bus.ScalVal !== 6'd10) begin
      n_bad++; $display("FAIL basic_symscal got sym=%b scal=%0d want 1 10", bus.isCoefSym, bus.ScalVal);
    end
    for (int a = 0; a < 8; a++) begin
      issue_read(a);
      tick();
      n_cmp++;
      if (bus.Coef_Rd_Data !== exp_rd[a]) begin
        n_bad++; $display("FAIL basic_rd addr=%0d got %h want %h", a, bus.Coef_Rd_Data, exp_rd[a]);
      end
    end
  endtask

  task automatic test_trunc();
    burst_w = '{32'h11, 32'h22, 32'hFF800001, 32'h44, 32'h55, 32'h1, 32'h0A};
    do_burst(-1, -1, -1, -1, N+6);
    issue_read(2);
    tick();
    n_cmp++;
    if (bus.Coef_Rd_Data !== 24'h800001) begin
      n_bad++; $display("FAIL trunc got %h want 800001", bus.Coef_Rd_Data);
    end
  endtask

  task automatic test_second_burst();
    burst_w = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h0, 32'h15};
    do_burst(-1, -1, 3, -1, N+6);
    n_cmp++;
    if (bus.Coef_Rd_Data !== 24'h104) begin
      n_bad++; $display("FAIL second_rd3 got %h want 104", bus.Coef_Rd_Data);
    end
    do_idle(2);
  endtask

  task automatic test_repulse();
    fill_random();
    do_burst(3, N+4, -1, -1, N+8);
    do_idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      fill_random();
      do_burst(-1, -1, -1, -1, N+4);
    end
    do_idle(3);
  endtask

  task automatic test_reset_mid();
    fill_random();
    do_burst(-1, -1, -1, 4, N+6);
    do_idle(2);
    fill_random();
    do_burst(-1, -1, -1, -1, N+6);
    do_idle(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      fill_random();
      do_burst(int'($urandom_range(1, N+4)), -1, -1, -1, N+5);
      do_idle(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_second_burst();
    test_repulse();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
